// File: rtl/rand_seed_gen_if.sv
// rand_seed_gen_if: button/seed inputs and secret-number outputs of rand_seed_gen
interface rand_seed_gen_if;
    logic       randBut;
    logic [3:0] seedSwitch;
    logic [3:0] randNum;
    logic       randValid;
    logic       newNum;
    logic       busy;

    modport master (
        output randBut, seedSwitch,
        input  randNum, randValid, newNum, busy
    );

    modport slave (
        input  randBut, seedSwitch,
        output randNum, randValid, newNum, busy
    );
endinterface

// File: rtl/rand_seed_gen.sv
// rand_seed_gen: debounced button-triggered LFSR secret number generator; FREE_RUN_EN mixes in a free-running LFSR
module rand_seed_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DB_W            = 20,
    parameter int STEPS           = 1
) (
    input logic            clk,
    input logic            reset_n,
    rand_seed_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_sync;
    logic            r_db, r_db_prev;
    logic [DB_W-1:0] r_cnt;
    logic [3:0]      r_lfsr, r_step, r_num;
    logic            r_valid, r_new;
    logic [3:0]      w_seed, w_load;
    logic            w_press;

    // two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], bus.randBut};
    end

    // accept a level change only after it has been stable long enough
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db      <= 1'b1;
            r_db_prev <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_db_prev <= r_db;
            if (r_sync[1] == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db  <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_db_prev & ~r_db;

`ifdef FREE_RUN_EN
    logic [3:0] r_free;

    // free-running LFSR makes the loaded value depend on press timing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_free <= 4'b0001;
        else          r_free <= {r_free[2:0], r_free[3] ^ r_free[2]};
    end

    assign w_seed = bus.seedSwitch ^ r_free;
`else
    assign w_seed = bus.seedSwitch;
`endif

    assign w_load = (w_seed == 4'b0000) ? 4'b0001 : w_seed;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // next-state logic; presses outside IDLE are simply ignored
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_press ? LOAD : IDLE;
            LOAD:    w_next = STEP;
            STEP:    w_next = (r_step == 4'(STEPS - 1)) ? DONE : STEP;
            default: w_next = IDLE;
        endcase
    end

    // LFSR load/step and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lfsr  <= 4'b0001;
            r_step  <= '0;
            r_num   <= '0;
            r_valid <= 1'b0;
            r_new   <= 1'b0;
        end else begin
            r_new <= (r_state == DONE);
            if (r_state == LOAD) begin
                r_lfsr <= w_load;
                r_step <= '0;
            end
            if (r_state == STEP) begin
                r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
                r_step <= r_step + 1'b1;
            end
            if (r_state == DONE) begin
                r_num   <= r_lfsr;
                r_valid <= 1'b1;
            end
        end
    end

    assign bus.randNum   = r_num;
    assign bus.randValid = r_valid;
    assign bus.newNum    = r_new;
    assign bus.busy      = (r_state != IDLE);
endmodule

// File: tb/tb_rand_seed_gen.sv
// tb_rand_seed_gen: scoreboard bench for rand_seed_gen (STEPS=1 and STEPS=4 instances)
module tb_rand_seed_gen;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rand_seed_gen_if if1();
    rand_seed_gen_if if4();

    rand_seed_gen #(.DEBOUNCE_CYCLES(16), .DB_W(20), .STEPS(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .bus(if1.slave)
    );
    rand_seed_gen #(.DEBOUNCE_CYCLES(1), .DB_W(20), .STEPS(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(if4.slave)
    );

    logic [3:0] q1[$];
    logic [3:0] q4[$];
    logic [3:0] last1 = 4'd0;
    logic [3:0] last4 = 4'd0;
    logic       pb1 = 1'b0;
    logic       pb4 = 1'b0;
    int         nn1 = 0, nn4 = 0, bc1 = 0, bc4 = 0;
    logic [3:0] fr;

    function automatic logic [3:0] nxt(input logic [3:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    function automatic logic [3:0] gen(input logic [3:0] s, input int steps);
        logic [3:0] v;
        v = (s == 4'd0) ? 4'd1 : s;
        for (int i = 0; i < steps; i++) v = nxt(v);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) fr <= 4'b0001;
        else          fr <= nxt(fr);
    end

    function automatic logic [3:0] mix(input logic [3:0] s);
`ifdef FREE_RUN_EN
        return s ^ fr;
`else
        return s;
`endif
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (if1.busy && !pb1) q1.push_back(gen(mix(if1.seedSwitch), 1));
            pb1 = if1.busy;
            if (if1.busy) bc1++;
            if (if1.newNum) begin
                nn1++;
                check("q1_nonempty", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    last1 = q1.pop_front();
                    check("randNum1", if1.randNum, last1);
                    check("randValid1", if1.randValid, 1);
                end
            end
        end else begin
            pb1 = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (if4.busy && !pb4) q4.push_back(gen(mix(if4.seedSwitch), 4));
            pb4 = if4.busy;
            if (if4.busy) bc4++;
            if (if4.newNum) begin
                nn4++;
                check("q4_nonempty", 32'(q4.size() != 0), 1);
                if (q4.size() != 0) begin
                    last4 = q4.pop_front();
                    check("randNum4", if4.randNum, last4);
                    check("randValid4", if4.randValid, 1);
                end
            end
        end else begin
            pb4 = 1'b0;
        end
    end

    task automatic press1(input logic [3:0] s, input int low);
        if1.seedSwitch = s;
        if1.randBut = 1'b0;
        repeat (low) @(negedge clk);
        if1.randBut = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int n0, b0;
        bit seen;
        if1.randBut = 1'b1;
        if1.seedSwitch = 4'd0;
        if4.randBut = 1'b1;
        if4.seedSwitch = 4'd0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_randNum", if1.randNum, 0);
        check("rst_randValid", if1.randValid, 0);
        check("rst_newNum", if1.newNum, 0);
        check("rst_busy", if1.busy, 0);
        check("rst_busy4", if4.busy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        n0 = nn1;
        b0 = bc1;
        press1(4'b1111, 40);
        check("hold_one_newNum", nn1 - n0, 1);
        check("hold_busy_cycles", bc1 - b0, 3);
        check("hold_valid", if1.randValid, 1);
        check("hold_idle", if1.busy, 0);
`ifndef FREE_RUN_EN
        check("hold_randNum", if1.randNum, 4'b1110);
`endif

        press1(4'b1010, 30);
`ifndef FREE_RUN_EN
        check("seed1010", if1.randNum, 4'b0101);
`endif
        press1(4'b0000, 30);
`ifndef FREE_RUN_EN
        check("seed0000", if1.randNum, 4'b0010);
`endif

        n0 = nn1;
        press1(4'b1111, 10);
        check("bounce_no_newNum", nn1 - n0, 0);
        check("bounce_hold", if1.randNum, last1);

        n0 = nn4;
        b0 = bc4;
        if4.seedSwitch = 4'b1111;
        if4.randBut = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = if4.busy;
        end
        check("dut4_started", 32'(seen), 1);
        if4.randBut = 1'b1;
        @(negedge clk);
        if4.seedSwitch = 4'b0000;
        if4.randBut = 1'b0;
        @(negedge clk);
        if4.randBut = 1'b1;
        repeat (20) @(negedge clk);
        check("dut4_one_newNum", nn4 - n0, 1);
        check("dut4_busy_cycles", bc4 - b0, 6);
`ifndef FREE_RUN_EN
        check("dut4_randNum", if4.randNum, 4'b0001);
`endif

        if1.seedSwitch = 4'b0110;
        if1.randBut = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = if1.busy;
        end
        check("rstmid_started", 32'(seen), 1);
        @(negedge clk);
        reset_n = 1'b0;
        if1.randBut = 1'b1;
        #1;
        check("rstmid_randNum", if1.randNum, 0);
        check("rstmid_valid", if1.randValid, 0);
        check("rstmid_busy", if1.busy, 0);
        check("rstmid_newNum", if1.newNum, 0);
        q1.delete();
        n0 = nn1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rstmid_no_newNum", nn1 - n0, 0);
        check("rstmid_valid_after", if1.randValid, 0);

`ifdef FREE_RUN_EN
        repeat (7) @(negedge clk);
        press1(4'b0101, 30);
        repeat (13) @(negedge clk);
        press1(4'b0101, 30);
`endif

        check("q1_drained", q1.size(), 0);
        check("q4_drained", q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
